// File: rtl/multicycle_controller.sv
// Control FSM for a multicycle RV32I datapath.
// Sequences each instruction through FETCH/DECODE and the per-class execute
// states, drives every datapath select and write-enable from the current
// state, parks the core in a sticky ERROR state on unsupported encodings and
// counts retired instructions for bring-up.
module multicycle_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op_code,
  input  logic [2:0]           funct3,
  input  logic [6:0]           funct7,
  input  logic                 Zero,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 IR_write,
  output logic                 reg_write,
  output logic                 PC_write,
  output logic [1:0]           result_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           imm_src,
  output logic [2:0]           alu_control,
  output logic                 illegal,
  output logic [3:0]           state_dbg,
  output logic [CNT_WIDTH-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ERROR    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] IMM_I = 2'd0;
  localparam logic [1:0] IMM_S = 2'd1;
  localparam logic [1:0] IMM_B = 2'd2;
  localparam logic [1:0] IMM_J = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 illegal_q, illegal_d;

  logic                 alu_f3_ok;
  logic                 br_f3_ok;
  logic [2:0]           alu_decoded;

  // Unstate-decoded enables, gated by reset before reaching the ports
  logic                 mem_write_s;
  logic                 IR_write_s;
  logic                 reg_write_s;
  logic                 PC_write_s;

  // Only funct7[5] selects between add and sub; the other bits are ignored
  logic                 unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // Which funct3 values the ALU and branch paths actually implement
  always_comb begin
    alu_f3_ok = !((funct3 == 3'b001) || (funct3 == 3'b011) || (funct3 == 3'b101));
    br_f3_ok  = (funct3 == 3'b000) || (funct3 == 3'b001);
  end

  // ALU operation for R/I execute; only R-type with funct7[5] subtracts
  always_comb begin
    alu_decoded = ALU_ADD;
    case (funct3)
      3'b000:  alu_decoded = (op_code[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_decoded = ALU_SLT;
      3'b100:  alu_decoded = ALU_XOR;
      3'b110:  alu_decoded = ALU_OR;
      3'b111:  alu_decoded = ALU_AND;
      default: alu_decoded = ALU_ADD;
    endcase
  end

  // Immediate format follows the opcode directly, independent of state
  always_comb begin
    imm_src = IMM_I;
    case (op_code)
      OP_LOAD,
      OP_ITYPE:  imm_src = IMM_I;
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;
    endcase
  end

  // Next-state selection; illegal encodings are caught once in DECODE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op_code)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = alu_f3_ok ? S_EXECR : S_ERROR;
          OP_ITYPE:  state_d = alu_f3_ok ? S_EXECI : S_ERROR;
          OP_BRANCH: state_d = br_f3_ok ? S_BRANCH : S_ERROR;
          OP_JAL:    state_d = S_JAL;
          default:   state_d = S_ERROR;
        endcase
      end
      S_MEMADR:   state_d = (op_code == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_ERROR;
    endcase
  end

  // Retire count bumps on the final cycle of every completed instruction
  always_comb begin
    retired_d = retired_q;
    if ((state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
        (state_q == S_ALUWB) || (state_q == S_BRANCH)) begin
      retired_d = retired_q + CNT_ONE;
    end
    illegal_d = illegal_q || (state_d == S_ERROR);
  end

  // State, sticky error flag and retire counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Moore decode of the datapath controls from the current state
  always_comb begin
    adr_src     = 1'b0;
    mem_write_s = 1'b0;
    IR_write_s  = 1'b0;
    reg_write_s = 1'b0;
    PC_write_s  = 1'b0;
    result_src  = 2'd0;
    alu_src_a   = 2'd0;
    alu_src_b   = 2'd0;
    alu_control = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        adr_src    = 1'b0;
        IR_write_s = 1'b1;
        alu_src_a  = 2'd0;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        PC_write_s = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'd1;
        alu_src_b = 2'd1;
      end
      S_MEMADR: begin
        alu_src_a = 2'd2;
        alu_src_b = 2'd1;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        result_src = 2'd0;
      end
      S_MEMWB: begin
        result_src  = 2'd1;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        result_src  = 2'd0;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'd2;
        alu_src_b   = 2'd0;
        alu_control = alu_decoded;
      end
      S_EXECI: begin
        alu_src_a   = 2'd2;
        alu_src_b   = 2'd1;
        alu_control = alu_decoded;
      end
      S_ALUWB: begin
        result_src  = 2'd0;
        reg_write_s = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a   = 2'd2;
        alu_src_b   = 2'd0;
        alu_control = ALU_SUB;
        result_src  = 2'd0;
        PC_write_s  = funct3[0] ? !Zero : Zero;
      end
      S_JAL: begin
        alu_src_a  = 2'd1;
        alu_src_b  = 2'd2;
        result_src = 2'd0;
        PC_write_s = 1'b1;
      end
      default: begin
        // ERROR and unused codes: every control held at zero
      end
    endcase
  end

  // Enables are killed while reset is low so no write can slip past the reset edge
  always_comb begin
    mem_write = mem_write_s && reset;
    IR_write  = IR_write_s  && reset;
    reg_write = reg_write_s && reset;
    PC_write  = PC_write_s  && reset;
  end

  assign illegal   = illegal_q;
  assign state_dbg = state_q;
  assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller.
// Each instruction is expanded by a behavioural model into its expected state
// walk and per-cycle control values; the DUT is compared on every cycle.
module tb_multicycle_controller;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    op_code;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic          Zero;
  logic          adr_src, mem_write, IR_write, reg_write, PC_write, illegal;
  logic [1:0]    result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0]    alu_control;
  logic [3:0]    state_dbg;
  logic [CW-1:0] retired;

  int n_cmp = 0;
  int n_bad = 0;
  int ret_model = 0;

  // Per-instruction observations for the scenario-level checks
  int         obs_cycles, obs_mw, obs_rw, obs_branch_pcw;
  logic [2:0] obs_exec_alu;

  logic [15:0] obs_vec;
  assign obs_vec = {adr_src, mem_write, IR_write, reg_write, PC_write,
                    result_src, alu_src_a, alu_src_b, alu_control, imm_src};

  multicycle_controller #(.CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .funct3(funct3),
    .funct7(funct7), .Zero(Zero), .adr_src(adr_src), .mem_write(mem_write),
    .IR_write(IR_write), .reg_write(reg_write), .PC_write(PC_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal),
    .state_dbg(state_dbg), .retired(retired)
  );

  always #5 clk = ~clk;

  // Model: expected state walk of one instruction (ends in 15 if unsupported)
  task automatic build_seq(input logic [6:0] op, input logic [2:0] f3,
                           output int seq[6], output int len, output bit legal);
    bit alu_bad;
    alu_bad = (f3 == 3'b001) || (f3 == 3'b011) || (f3 == 3'b101);
    for (int i = 0; i < 6; i++) seq[i] = 0;
    seq[0] = 0; seq[1] = 1; legal = 1'b1;
    if (op == 7'b0000011) begin seq[2] = 2; seq[3] = 3; seq[4] = 4; len = 5; end
    else if (op == 7'b0100011) begin seq[2] = 2; seq[3] = 5; len = 4; end
    else if (op == 7'b0110011 && !alu_bad) begin seq[2] = 6; seq[3] = 8; len = 4; end
    else if (op == 7'b0010011 && !alu_bad) begin seq[2] = 7; seq[3] = 8; len = 4; end
    else if (op == 7'b1100011 && f3 <= 3'b001) begin seq[2] = 9; len = 3; end
    else if (op == 7'b1101111) begin seq[2] = 10; seq[3] = 8; len = 4; end
    else begin seq[2] = 15; len = 3; legal = 1'b0; end
  endtask

  function automatic logic [1:0] exp_imm(input logic [6:0] op);
    if (op == 7'b0100011) return 2'd1;
    if (op == 7'b1100011) return 2'd2;
    if (op == 7'b1101111) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [2:0] exp_alu_op(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7);
    case (f3)
      3'b000:  return (op[5] && f7[5]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b100:  return 3'b100;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Model: control values expected while the instruction sits in state st
  function automatic logic [15:0] exp_vec(input int st, input logic [6:0] op,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic z);
    logic adr, mw, irw, rw, pcw;
    logic [1:0] rs, a, b;
    logic [2:0] alu;
    adr = 0; mw = 0; irw = 0; rw = 0; pcw = 0; rs = 0; a = 0; b = 0; alu = 0;
    case (st)
      0:  begin irw = 1; b = 2; rs = 2; pcw = 1; end
      1:  begin a = 1; b = 1; end
      2:  begin a = 2; b = 1; end
      3:  begin adr = 1; end
      4:  begin rs = 1; rw = 1; end
      5:  begin adr = 1; mw = 1; end
      6:  begin a = 2; b = 0; alu = exp_alu_op(op, f3, f7); end
      7:  begin a = 2; b = 1; alu = exp_alu_op(op, f3, f7); end
      8:  begin rw = 1; end
      9:  begin a = 2; alu = 3'b001; pcw = (f3 == 3'b000) ? z : !z; end
      10: begin a = 1; b = 2; pcw = 1; end
      default: ;
    endcase
    return {adr, mw, irw, rw, pcw, rs, a, b, alu, exp_imm(op)};
  endfunction

  // Drives one instruction and compares every cycle against the model
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic z);
    int seq[6];
    int len;
    bit legal;
    op_code = op; funct3 = f3; funct7 = f7; Zero = z;
    build_seq(op, f3, seq, len, legal);
    obs_cycles = 0; obs_mw = 0; obs_rw = 0; obs_branch_pcw = 0; obs_exec_alu = 3'bxxx;
    #0;
    for (int i = 0; i < len; i++) begin
      n_cmp++;
      if (state_dbg !== 4'(seq[i])) begin
        n_bad++;
        $display("FAIL state op=%b f3=%b step %0d: got %0d expected %0d", op, f3, i, state_dbg, seq[i]);
      end
      n_cmp++;
      if (obs_vec !== exp_vec(seq[i], op, f3, f7, z)) begin
        n_bad++;
        $display("FAIL controls op=%b f3=%b state %0d: got %h expected %h",
                 op, f3, seq[i], obs_vec, exp_vec(seq[i], op, f3, f7, z));
      end
      n_cmp++;
      if (illegal !== (seq[i] == 15)) begin
        n_bad++;
        $display("FAIL illegal state %0d: got %b expected %b", seq[i], illegal, seq[i] == 15);
      end
      obs_cycles++;
      if (mem_write === 1'b1) obs_mw++;
      if (reg_write === 1'b1) obs_rw++;
      if (state_dbg == 4'd9 && PC_write === 1'b1) obs_branch_pcw++;
      if (state_dbg == 4'd6 || state_dbg == 4'd7) obs_exec_alu = alu_control;
      @(posedge clk); #1;
    end
    if (legal) begin
      ret_model++;
      n_cmp++;
      if (state_dbg !== 4'd0 || retired !== CW'(ret_model % 16)) begin
        n_bad++;
        $display("FAIL retire op=%b: got state %0d retired %0d expected state 0 retired %0d",
                 op, state_dbg, retired, ret_model % 16);
      end
    end else begin
      for (int c = 0; c < 10; c++) begin
        n_cmp++;
        if (state_dbg !== 4'd15 || illegal !== 1'b1 ||
            {mem_write, IR_write, reg_write, PC_write} !== 4'b0000) begin
          n_bad++;
          $display("FAIL error_hold cycle %0d: got state %0d illegal %b en %b expected 15 1 0000",
                   c, state_dbg, illegal, {mem_write, IR_write, reg_write, PC_write});
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // Asynchronous reset mid-cycle; releases so the next sample is in FETCH
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    ret_model = 0;
    n_cmp++;
    if (state_dbg !== 4'd0 || illegal !== 1'b0 || retired !== '0 ||
        {mem_write, IR_write, reg_write, PC_write} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_async: got state %0d illegal %b retired %0d en %b expected 0 0 0 0000",
               state_dbg, illegal, retired, {mem_write, IR_write, reg_write, PC_write});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (state_dbg !== 4'd0 || IR_write !== 1'b1 || PC_write !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: got state %0d IR_write %b PC_write %b expected 0 1 1",
               state_dbg, IR_write, PC_write);
    end
  endtask

  task automatic test_r_sub();
    run_instr(7'b0110011, 3'b000, 7'b0100000, 1'b0);
    n_cmp++;
    if (obs_exec_alu !== 3'b001 || obs_rw != 1 || obs_cycles != 4 || retired !== CW'(1)) begin
      n_bad++;
      $display("FAIL r_sub: got alu %b rw %0d cycles %0d retired %0d expected 001 1 4 1",
               obs_exec_alu, obs_rw, obs_cycles, retired);
    end
  endtask

  task automatic test_load();
    run_instr(7'b0000011, 3'b010, 7'b0000000, 1'b0);
    n_cmp++;
    if (obs_cycles != 5 || obs_rw != 1 || imm_src !== 2'd0) begin
      n_bad++;
      $display("FAIL load: got cycles %0d rw %0d imm %0d expected 5 1 0", obs_cycles, obs_rw, imm_src);
    end
  endtask

  task automatic test_store();
    run_instr(7'b0100011, 3'b010, 7'b0000000, 1'b1);
    n_cmp++;
    if (obs_cycles != 4 || obs_mw != 1 || obs_rw != 0 || imm_src !== 2'd1) begin
      n_bad++;
      $display("FAIL store: got cycles %0d mw %0d rw %0d imm %0d expected 4 1 0 1",
               obs_cycles, obs_mw, obs_rw, imm_src);
    end
  endtask

  task automatic test_branch();
    run_instr(7'b1100011, 3'b000, 7'b0000000, 1'b1);
    n_cmp++;
    if (obs_cycles != 3 || obs_branch_pcw != 1) begin
      n_bad++;
      $display("FAIL beq_taken: got cycles %0d pcw %0d expected 3 1", obs_cycles, obs_branch_pcw);
    end
    run_instr(7'b1100011, 3'b001, 7'b0000000, 1'b1);
    n_cmp++;
    if (obs_cycles != 3 || obs_branch_pcw != 0) begin
      n_bad++;
      $display("FAIL bne_not_taken: got cycles %0d pcw %0d expected 3 0", obs_cycles, obs_branch_pcw);
    end
  endtask

  task automatic test_jal();
    run_instr(7'b1101111, 3'b000, 7'b0000000, 1'b0);
    n_cmp++;
    if (obs_cycles != 4 || obs_rw != 1 || imm_src !== 2'd3) begin
      n_bad++;
      $display("FAIL jal: got cycles %0d rw %0d imm %0d expected 4 1 3", obs_cycles, obs_rw, imm_src);
    end
  endtask

  task automatic test_illegal();
    run_instr(7'b1110011, 3'b000, 7'b0000000, 1'b0);
    do_reset();
    run_instr(7'b0010011, 3'b101, 7'b0000000, 1'b0);
    do_reset();
    run_instr(7'b1100011, 3'b100, 7'b0000000, 1'b0);
    do_reset();
  endtask

  // Reset landing while a store is writing must drop mem_write at once
  task automatic test_reset_mid();
    op_code = 7'b0100011; funct3 = 3'b010; funct7 = 7'b0; Zero = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if (state_dbg !== 4'd5 || mem_write !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_setup: got state %0d mem_write %b expected 5 1", state_dbg, mem_write);
    end
    do_reset();
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 16; k++) begin
      run_instr(7'b0010011, 3'b000, 7'b0000000, 1'b0);
      if (k == 14) begin
        n_cmp++;
        if (retired !== CW'(15)) begin
          n_bad++;
          $display("FAIL wrap_15: got %0d expected 15", retired);
        end
      end
    end
    n_cmp++;
    if (retired !== '0) begin
      n_bad++;
      $display("FAIL wrap_0: got %0d expected 0", retired);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] pool [8];
    logic [6:0] op, f7;
    logic [2:0] f3;
    int seq[6];
    int len;
    bit legal;
    pool = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
             7'b1100011, 7'b1101111, 7'b0110111, 7'b1110011};
    for (int n = 0; n < 80; n++) begin
      op = pool[$urandom_range(7, 0)];
      f3 = 3'($urandom_range(7, 0));
      case ($urandom_range(2, 0))
        0: f7 = 7'b0000000;
        1: f7 = 7'b0100000;
        default: f7 = 7'($urandom);
      endcase
      build_seq(op, f3, seq, len, legal);
      run_instr(op, f3, f7, 1'($urandom));
      if (!legal) do_reset();
    end
  endtask

  initial begin
    reset = 1'b1; op_code = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0100000; Zero = 1'b0;
    #1;
    test_reset();
    test_r_sub();
    test_load();
    test_store();
    test_branch();
    test_jal();
    test_illegal();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
